// File: rtl/main_sort_pkg.sv
// main_sort_pkg: shared types and helpers for the Avalon-ST packet sorter.
package main_sort_pkg;

  // Top-level packet flow: collect words, sort them in place, stream them out.
  typedef enum logic [1:0] {
    RECV,
    SORT,
    SEND
  } state_e;

  // Sub-steps of one bubble pass. P_LOAD issues the read of word 0, P_FIRST
  // captures it as the running carry, P_STEP handles one compare/swap per
  // cycle, and P_TAIL writes the largest value of the pass to the last slot.
  typedef enum logic [1:0] {
    P_LOAD,
    P_FIRST,
    P_STEP,
    P_TAIL
  } sort_phase_e;

  // Width of length/index counters; must be able to hold MAX_PKT_LEN itself.
  function automatic int idx_width(input int max_len);
    return $clog2(max_len + 1);
  endfunction

endpackage

// File: rtl/main_sort_ram.sv
// main_sort_ram: simple dual-port packet buffer, one write port and one
// registered read port on the same clock.
module main_sort_ram #(
  parameter int DWIDTH = 8,
  parameter int DEPTH  = 32,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic              clk_i,
  input  logic              wr_en_i,
  input  logic [AW-1:0]     wr_addr_i,
  input  logic [DWIDTH-1:0] wr_data_i,
  input  logic [AW-1:0]     rd_addr_i,
  output logic [DWIDTH-1:0] rd_data_o
);

  logic [DWIDTH-1:0] mem_q [DEPTH];
  logic [DWIDTH-1:0] rd_data_q;

  // Write port: one word per cycle when enabled.
  always_ff @(posedge clk_i) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  // Read port: data for an address appears one cycle after it is presented.
  always_ff @(posedge clk_i) begin
    rd_data_q <= mem_q[rd_addr_i];
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/main_sort.sv
// main_sort: receives one Avalon-ST packet, bubble-sorts it ascending in a
// buffer RAM and re-emits it with fresh start/end framing.
module main_sort #(
  parameter int DWIDTH      = 8,
  parameter int MAX_PKT_LEN = 32
) (
  input  logic              clk_i,
  input  logic              srst_i,
  input  logic [DWIDTH-1:0] snk_data_i,
  input  logic              snk_startofpacket_i,
  input  logic              snk_endofpacket_i,
  input  logic              snk_valid_i,
  output logic              snk_ready_o,
  output logic [DWIDTH-1:0] src_data_o,
  output logic              src_startofpacket_o,
  output logic              src_endofpacket_o,
  output logic              src_valid_o,
  input  logic              src_ready_i
);

  import main_sort_pkg::*;

  localparam int IW = idx_width(MAX_PKT_LEN);
  localparam int AW = $clog2(MAX_PKT_LEN);
  localparam logic [IW-1:0] MAX_LEN = IW'(MAX_PKT_LEN);
  localparam logic [IW-1:0] ONE     = IW'(1);

  state_e            state_q, state_d;
  sort_phase_e       phase_q, phase_d;
  logic [IW-1:0]     len_q, len_d, idx_q, idx_d, pass_q, pass_d;
  logic              in_pkt_q, in_pkt_d, swapped_q, swapped_d, fetch_v_q, fetch_v_d;
  logic [DWIDTH-1:0] carry_q, carry_d, out_data_q, out_data_d;
  logic              out_sop_q, out_sop_d, out_eop_q, out_eop_d, out_valid_q, out_valid_d;

  logic              ram_we;
  logic [AW-1:0]     ram_waddr, ram_raddr;
  logic [DWIDTH-1:0] ram_wdata, ram_rdata;

  logic              accept, pkt_word, closing, at_last, sort_done, tx_fire, send_done, load;
  logic [IW-1:0]     rx_len, len_m1, idx_p1;

  main_sort_ram #(
    .DWIDTH(DWIDTH),
    .DEPTH (MAX_PKT_LEN),
    .AW    (AW)
  ) u_ram (
    .clk_i    (clk_i),
    .wr_en_i  (ram_we),
    .wr_addr_i(ram_waddr),
    .wr_data_i(ram_wdata),
    .rd_addr_i(ram_raddr),
    .rd_data_o(ram_rdata)
  );

  // Words outside a packet (before any SOP) are accepted but dropped; a SOP
  // always restarts at index 0. The MAX_PKT_LEN-th word closes the packet.
  assign accept    = (state_q == RECV) && snk_valid_i;
  assign pkt_word  = accept && (snk_startofpacket_i || in_pkt_q);
  assign rx_len    = snk_startofpacket_i ? ONE : len_q + ONE;
  assign closing   = pkt_word && (snk_endofpacket_i || rx_len == MAX_LEN);
  assign len_m1    = len_q - ONE;
  assign idx_p1    = idx_q + ONE;
  assign at_last   = (idx_q == len_m1);
  assign sort_done = (phase_q == P_TAIL) && (!swapped_q || (pass_q + ONE) == len_m1);
  assign tx_fire   = out_valid_q && src_ready_i;
  assign send_done = (state_q == SEND) && tx_fire && out_eop_q;
  assign load      = (state_q == SEND) && fetch_v_q && (idx_q != len_q) &&
                     (!out_valid_q || src_ready_i);

  assign snk_ready_o         = (state_q == RECV) && !srst_i;
  assign src_data_o          = out_data_q;
  assign src_startofpacket_o = out_sop_q;
  assign src_endofpacket_o   = out_eop_q;
  assign src_valid_o         = out_valid_q;

  // State register.
  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      state_q <= RECV;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: single-word packets skip the sort entirely.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      RECV:    if (closing)   state_d = (rx_len == ONE) ? SEND : SORT;
      SORT:    if (sort_done) state_d = SEND;
      SEND:    if (send_done) state_d = RECV;
      default: state_d = RECV;
    endcase
  end

  // Datapath and output control: buffer writes, carry-based bubble passes and
  // a prefetching output stage that keeps the RAM read address steady during
  // back-pressure so the prefetched word stays valid.
  always_comb begin
    len_d       = len_q;
    idx_d       = idx_q;
    pass_d      = pass_q;
    phase_d     = phase_q;
    in_pkt_d    = in_pkt_q;
    swapped_d   = swapped_q;
    fetch_v_d   = fetch_v_q;
    carry_d     = carry_q;
    out_data_d  = out_data_q;
    out_sop_d   = out_sop_q;
    out_eop_d   = out_eop_q;
    out_valid_d = out_valid_q;
    ram_we      = 1'b0;
    ram_waddr   = '0;
    ram_wdata   = snk_data_i;
    ram_raddr   = '0;
    unique case (state_q)
      RECV: begin
        phase_d   = P_LOAD;
        idx_d     = '0;
        pass_d    = '0;
        fetch_v_d = 1'b0;
        if (pkt_word) begin
          ram_we    = 1'b1;
          ram_waddr = snk_startofpacket_i ? '0 : len_q[AW-1:0];
          len_d     = rx_len;
          in_pkt_d  = !closing;
        end
      end
      SORT: begin
        unique case (phase_q)
          P_LOAD: phase_d = P_FIRST;
          P_FIRST: begin
            carry_d   = ram_rdata;
            ram_raddr = AW'(1);
            idx_d     = ONE;
            swapped_d = 1'b0;
            phase_d   = P_STEP;
          end
          P_STEP: begin
            ram_we    = 1'b1;
            ram_waddr = idx_q[AW-1:0] - 1'b1;
            if (carry_q > ram_rdata) begin
              ram_wdata = ram_rdata;
              swapped_d = 1'b1;
            end else begin
              ram_wdata = carry_q;
              carry_d   = ram_rdata;
            end
            if (at_last) begin
              phase_d = P_TAIL;
            end else begin
              idx_d     = idx_p1;
              ram_raddr = idx_p1[AW-1:0];
            end
          end
          P_TAIL: begin
            ram_we    = 1'b1;
            ram_waddr = len_m1[AW-1:0];
            ram_wdata = carry_q;
            pass_d    = pass_q + ONE;
            phase_d   = P_LOAD;
            idx_d     = '0;
            fetch_v_d = 1'b0;
          end
          default: phase_d = P_LOAD;
        endcase
      end
      SEND: begin
        fetch_v_d = 1'b1;
        ram_raddr = idx_q[AW-1:0];
        if (tx_fire) begin
          out_valid_d = 1'b0;
          out_sop_d   = 1'b0;
          out_eop_d   = 1'b0;
        end
        if (load) begin
          out_data_d  = ram_rdata;
          out_sop_d   = (idx_q == '0);
          out_eop_d   = at_last;
          out_valid_d = 1'b1;
          idx_d       = idx_p1;
          ram_raddr   = idx_p1[AW-1:0];
        end
        if (send_done) begin
          len_d = '0;
          idx_d = '0;
        end
      end
      default: ;
    endcase
  end

  // Datapath registers; reset discards any packet in flight.
  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      len_q       <= '0;
      idx_q       <= '0;
      pass_q      <= '0;
      phase_q     <= P_LOAD;
      in_pkt_q    <= 1'b0;
      swapped_q   <= 1'b0;
      fetch_v_q   <= 1'b0;
      carry_q     <= '0;
      out_data_q  <= '0;
      out_sop_q   <= 1'b0;
      out_eop_q   <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      len_q       <= len_d;
      idx_q       <= idx_d;
      pass_q      <= pass_d;
      phase_q     <= phase_d;
      in_pkt_q    <= in_pkt_d;
      swapped_q   <= swapped_d;
      fetch_v_q   <= fetch_v_d;
      carry_q     <= carry_d;
      out_data_q  <= out_data_d;
      out_sop_q   <= out_sop_d;
      out_eop_q   <= out_eop_d;
      out_valid_q <= out_valid_d;
    end
  end

endmodule

// File: tb/tb_main_sort.sv
// tb_main_sort: scoreboard bench for the packet sorter.
module tb_main_sort;

  localparam int DW   = 8;
  localparam int MAXL = 32;

  typedef struct {
    logic [DW-1:0] data;
    logic          sop;
    logic          eop;
  } exp_t;

  logic          clk = 1'b0;
  logic          srst = 1'b1;
  logic [DW-1:0] snk_data = '0;
  logic          snk_sop = 1'b0;
  logic          snk_eop = 1'b0;
  logic          snk_valid = 1'b0;
  logic          snk_ready_o;
  logic [DW-1:0] src_data_o;
  logic          src_sop_o;
  logic          src_eop_o;
  logic          src_valid_o;
  logic          src_ready = 1'b1;

  exp_t          exp_q[$];
  int            n_checks = 0;
  int            n_fail = 0;
  int            tx_count = 0;
  int            ready_pct = 100;
  logic [DW-1:0] pkt[MAXL];
  int            pkt_len = 0;

  main_sort #(.DWIDTH(DW), .MAX_PKT_LEN(MAXL)) dut (
    .clk_i              (clk),
    .srst_i             (srst),
    .snk_data_i         (snk_data),
    .snk_startofpacket_i(snk_sop),
    .snk_endofpacket_i  (snk_eop),
    .snk_valid_i        (snk_valid),
    .snk_ready_o        (snk_ready_o),
    .src_data_o         (src_data_o),
    .src_startofpacket_o(src_sop_o),
    .src_endofpacket_o  (src_eop_o),
    .src_valid_o        (src_valid_o),
    .src_ready_i        (src_ready)
  );

  always #5 clk = ~clk;

  // Sink back-pressure, redrawn shortly after each rising edge.
  always begin
    @(posedge clk);
    #2;
    src_ready = (int'($urandom_range(99, 0)) < ready_pct);
  end

  // Output monitor: every presented word, stalled or not, must match the
  // head of the expected queue; the head is retired when the word transfers.
  always @(negedge clk) begin
    if (!srst && src_valid_o) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("[TB] FAIL unexpected_output data=%0h sop=%0b eop=%0b", src_data_o, src_sop_o, src_eop_o);
      end else begin
        if (src_data_o !== exp_q[0].data || src_sop_o !== exp_q[0].sop || src_eop_o !== exp_q[0].eop) begin
          n_fail++;
          $display("[TB] FAIL out_word got data=%0h sop=%0b eop=%0b want data=%0h sop=%0b eop=%0b",
                   src_data_o, src_sop_o, src_eop_o, exp_q[0].data, exp_q[0].sop, exp_q[0].eop);
        end
        if (src_ready) begin
          void'(exp_q.pop_front());
          tx_count++;
        end
      end
    end
  end

  // Pushes the sorted reference for pkt[0..pkt_len-1], then drives the packet
  // at the given valid density, honouring snk_ready_o.
  task automatic send_packet(input int density);
    logic [DW-1:0] srt[MAXL];
    logic [DW-1:0] t;
    int i, j, cyc;
    for (int k = 0; k < pkt_len; k++) srt[k] = pkt[k];
    for (int k = 1; k < pkt_len; k++) begin
      t = srt[k];
      j = k - 1;
      while (j >= 0 && srt[j] > t) begin
        srt[j+1] = srt[j];
        j--;
      end
      srt[j+1] = t;
    end
    for (int k = 0; k < pkt_len; k++) exp_q.push_back('{srt[k], (k == 0), (k == pkt_len - 1)});
    i = 0;
    cyc = 0;
    while (i < pkt_len && cyc < 20000) begin
      @(posedge clk);
      #2;
      if (int'($urandom_range(100, 1)) <= density) begin
        snk_valid = 1'b1;
        snk_data  = pkt[i];
        snk_sop   = (i == 0);
        snk_eop   = (i == pkt_len - 1);
      end else begin
        snk_valid = 1'b0;
        snk_data  = DW'($urandom);
        snk_sop   = 1'b0;
        snk_eop   = 1'b0;
      end
      @(negedge clk);
      if (snk_valid && snk_ready_o) i++;
      cyc++;
    end
    @(posedge clk);
    #2;
    snk_valid = 1'b0;
    snk_sop   = 1'b0;
    snk_eop   = 1'b0;
    n_checks++;
    if (i != pkt_len) begin
      n_fail++;
      $display("[TB] FAIL send_timeout accepted=%0d want=%0d", i, pkt_len);
    end
    @(negedge clk);
    n_checks++;
    if (snk_ready_o !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL ready_drop snk_ready=%0b want=0", snk_ready_o);
    end
  endtask

  // Drives one word outside the scoreboard (stray or to-be-discarded words).
  task automatic drive_word(input logic [DW-1:0] d, input logic s, input logic e);
    int cyc;
    logic done;
    cyc = 0;
    done = 1'b0;
    while (!done && cyc < 2000) begin
      @(posedge clk);
      #2;
      snk_valid = 1'b1;
      snk_data  = d;
      snk_sop   = s;
      snk_eop   = e;
      @(negedge clk);
      done = snk_ready_o;
      cyc++;
    end
    @(posedge clk);
    #2;
    snk_valid = 1'b0;
    snk_sop   = 1'b0;
    snk_eop   = 1'b0;
    n_checks++;
    if (!done) begin
      n_fail++;
      $display("[TB] FAIL drive_word_timeout accepted=0 want=1");
    end
  endtask

  // Waits for all expected words to leave, then checks the block is idle.
  task automatic wait_drain(input string name);
    int cyc;
    cyc = 0;
    while (exp_q.size() != 0 && cyc < 20000) begin
      @(negedge clk);
      cyc++;
    end
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("[TB] FAIL %s_drain left=%0d want=0", name, exp_q.size());
    end
    @(posedge clk);
    #2;
    @(negedge clk);
    n_checks++;
    if (snk_ready_o !== 1'b1 || src_valid_o !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL %s_idle snk_ready=%0b src_valid=%0b want 1/0", name, snk_ready_o, src_valid_o);
    end
  endtask

  task automatic test_reset();
    srst = 1'b1;
    @(posedge clk);
    #1;
    n_checks++;
    if ({src_valid_o, src_sop_o, src_eop_o, snk_ready_o, src_data_o} !== '0) begin
      n_fail++;
      $display("[TB] FAIL reset_outputs got v=%0b s=%0b e=%0b r=%0b d=%0h want all 0",
               src_valid_o, src_sop_o, src_eop_o, snk_ready_o, src_data_o);
    end
    #1 srst = 1'b0;
    @(posedge clk);
    #1;
    n_checks++;
    if (snk_ready_o !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL reset_ready got=%0b want=1", snk_ready_o);
    end
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      n_checks++;
      if (src_valid_o !== 1'b0) begin
        n_fail++;
        $display("[TB] FAIL reset_idle_valid got=%0b want=0", src_valid_o);
      end
    end
  endtask

  task automatic test_single();
    int n;
    drive_word(8'h11, 1'b0, 1'b1);
    pkt[0] = 8'h5A;
    pkt_len = 1;
    send_packet(100);
    n = 1;
    while (!src_valid_o && n < 10) begin
      @(negedge clk);
      n++;
    end
    n_checks++;
    if (n > 4) begin
      n_fail++;
      $display("[TB] FAIL single_latency got=%0d cycles want<=4", n);
    end
    wait_drain("single");
  endtask

  task automatic test_eight();
    int start;
    logic [DW-1:0] v[8];
    v = '{8'd7, 8'd3, 8'd255, 8'd0, 8'd3, 8'd128, 8'd1, 8'd9};
    for (int k = 0; k < 8; k++) pkt[k] = v[k];
    pkt_len = 8;
    start = tx_count;
    send_packet(20);
    wait_drain("eight");
    repeat (4) @(negedge clk);
    n_checks++;
    if (tx_count - start != 8) begin
      n_fail++;
      $display("[TB] FAIL eight_transfers got=%0d want=8", tx_count - start);
    end
  endtask

  task automatic test_full();
    for (int k = 0; k < MAXL; k++) pkt[k] = DW'(MAXL - 1 - k);
    pkt_len = MAXL;
    send_packet(100);
    wait_drain("descending");
    for (int k = 0; k < MAXL; k++) pkt[k] = DW'(k);
    send_packet(100);
    wait_drain("presorted");
    for (int k = 0; k < MAXL; k++) pkt[k] = 8'hAA;
    send_packet(100);
    wait_drain("all_equal");
  endtask

  task automatic test_stall();
    ready_pct = 50;
    for (int k = 0; k < 16; k++) pkt[k] = DW'($urandom);
    pkt_len = 16;
    send_packet(100);
    wait_drain("stall");
    ready_pct = 100;
  endtask

  task automatic test_restart();
    drive_word(8'hF0, 1'b1, 1'b0);
    drive_word(8'hF1, 1'b0, 1'b0);
    for (int k = 0; k < 5; k++) pkt[k] = DW'(50 - 7 * k);
    pkt_len = 5;
    send_packet(60);
    wait_drain("restart");
  endtask

  task automatic test_random();
    int dens;
    ready_pct = 80;
    for (int p = 0; p < 100; p++) begin
      dens = (p % 3 == 0) ? 20 : ((p % 3 == 1) ? 60 : 100);
      pkt_len = int'($urandom_range(MAXL, 2));
      for (int k = 0; k < pkt_len; k++) pkt[k] = DW'($urandom);
      send_packet(dens);
    end
    wait_drain("random");
    ready_pct = 100;
  endtask

  task automatic test_abort();
    int cyc;
    for (int k = 0; k < 16; k++) pkt[k] = DW'($urandom);
    pkt_len = 16;
    send_packet(100);
    cyc = 0;
    while (!src_valid_o && cyc < 3000) begin
      @(negedge clk);
      cyc++;
    end
    n_checks++;
    if (!src_valid_o) begin
      n_fail++;
      $display("[TB] FAIL abort_wait src_valid=0 want=1");
    end
    @(posedge clk);
    #2 srst = 1'b1;
    @(posedge clk);
    #2 srst = 1'b0;
    exp_q.delete();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      n_checks++;
      if (src_valid_o !== 1'b0 || snk_ready_o !== 1'b1) begin
        n_fail++;
        $display("[TB] FAIL abort_idle src_valid=%0b snk_ready=%0b want 0/1", src_valid_o, snk_ready_o);
      end
    end
    for (int k = 0; k < 10; k++) pkt[k] = DW'($urandom);
    pkt_len = 10;
    send_packet(60);
    wait_drain("after_abort");
  endtask

  initial begin
    $display("[TB] starting main_sort bench");
    test_reset();
    test_single();
    test_eight();
    test_full();
    test_stall();
    test_restart();
    test_random();
    test_abort();
    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/main_sort.md
# main_sort

Avalon-ST packet sorter sitting between an upstream Avalon-ST source and a downstream sink. It receives one packet of up to MAX_PKT_LEN unsigned words, sorts it in ascending order, and re-emits it as one packet of the same length with correct start/end framing. It handles one packet at a time and back-pressures its input while sorting and sending.

## Interface
- DWIDTH, 8: word width in bits; words compare as unsigned.
- MAX_PKT_LEN, 32: maximum words per packet (≥2; up to 2048 supported).

Ports:
- clk_i  in  1  single clock; everything is rising-edge.
- srst_i  in  1  reset, synchronous and active-high.
- snk_data_i  in  DWIDTH  input word.
- snk_startofpacket_i  in  1  first word of input packet.
- snk_endofpacket_i  in  1  last word of input packet.
- snk_valid_i  in  1  input word valid.
- snk_ready_o  out  1  block can accept a word.
- src_data_o  out  DWIDTH  output word.
- src_startofpacket_o  out  1  first (smallest) output word.
- src_endofpacket_o  out  1  last (largest) output word.
- src_valid_o  out  1  output word valid.
- src_ready_i  in  1  sink accepts the word.

## Operation
- FSM states: RECV, SORT, SEND.
- Reset → RECV with length 0. All outputs 0 while srst_i is high. srst_i high at any time aborts the current packet; no partial output is emitted afterwards.
- RECV:
  - snk_ready_o = 1. A word is accepted when snk_valid_i & snk_ready_o.
  - Accepted words are ignored until one carries SOP.
  - An SOP word restarts the packet at index 0, even mid-packet.
  - Words are written to the buffer at index len, then len increments.
  - An accepted EOP word closes the packet. So does the MAX_PKT_LEN-th word, whether or not it carries EOP.
  - A word with SOP and EOP set together is a 1-word packet.
  - When the packet closes: go to SORT, or straight to SEND if len = 1.
- SORT:
  - snk_ready_o = 0.
  - In-place bubble sort over buffer[0..len-1], ascending, unsigned compare.
  - Each pass does len-1 compare/swap steps. The sort ends after the first pass with no swap, or after len-1 passes.
  - Equal values are kept (duplicates preserved). Go to SEND.
- SEND:
  - snk_ready_o = 0.
  - Words are presented from index 0 to len-1 with src_valid_o = 1.
  - src_startofpacket_o = 1 on index 0; src_endofpacket_o = 1 on index len-1 (both on a 1-word packet).
  - The index advances only when src_valid_o & src_ready_i.
  - After the EOP word transfers: src_valid_o = 0, len = 0, go to RECV.
- Output length always equals input length; the output is a permutation of the input.

## Timing
- src_* outputs are registered. While src_valid_o = 1 and src_ready_i = 0, data, SOP and EOP hold stable.
- Back-to-back output transfers at 1 word/cycle when src_ready_i stays 1.
- snk_ready_o drops in the cycle after the closing word is accepted. It rises again in the cycle after the output EOP transfers.
- First output word is valid no later than 4·len·len + 8 cycles after the closing input word is accepted; sooner on early termination.
- A 1-word packet appears on the output within 4 cycles.
- Buffer RAM read latency is 1 cycle; the FSM accounts for it, with no combinational RAM read paths to the outputs.
- Counters/indices are $clog2(MAX_PKT_LEN+1) bits wide; no wrap-around, since len never exceeds MAX_PKT_LEN.

## Structure
- Package main_sort_pkg:
  - state enum (RECV, SORT, SEND);
  - function computing the index width from MAX_PKT_LEN.
- Sub-module main_sort_ram:
  - simple dual-port RAM, MAX_PKT_LEN × DWIDTH;
  - one write port, one read port, registered read, same clock;
  - used by the top for buffering and by the sort engine for compare/swap.
- Top holds the FSM, counters, compare/swap sequencer and output register.

## Test plan
- Reset: srst_i high 1 cycle → all outputs 0 during reset; snk_ready_o = 1 the cycle after; src_valid_o stays 0 with no input.
- 1-word packet 0x5A with SOP+EOP → one output word 0x5A with SOP=EOP=1.
- 8-word packet {7,3,255,0,3,128,1,9}, valid asserted 20% of cycles, src_ready_i = 1 → output {0,1,3,3,7,9,128,255}; SOP on 0, EOP on 255; exactly 8 transfers.
- Full packet, MAX_PKT_LEN = 32, descending 31..0 → ascending 0..31. Also check an already-sorted input (early exit) and all-equal input (32 × 0xAA).
- Random src_ready_i (50%) during a 16-word random packet → data, SOP and EOP stable while stalled; output equals the sorted input.
- 100 random packets with lengths 2..MAX_PKT_LEN and valid density 20/60/100% → each output equals the reference sort with matching length; no words accepted while snk_ready_o = 0; srst_i asserted mid-SEND aborts and the next packet sorts correctly.
